fdtd_run_sequencer: RTL
=======================

# fdtd_run_sequencer

Control stage directly upstream of the 8-bit finish/status input PIO read by the Nios II. Runs a programmed number of FDTD time steps. For each step it issues a one-cycle start pulse to the FDTD datapath and waits for that step's done pulse, with a per-step watchdog. It drives a registered 8-bit status byte, wired straight to the PIO `in_port`, so software can poll finish, busy, error and abort state.

## Interface
Parameters:
- `STEP_W`, 16, width of the step count and step counter.
- `TIMEOUT_CYCLES`, 1000000, cycles allowed in WAIT per step before timeout. Legal range 1 to 2^24-1.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled each cycle. Honoured only in IDLE or DONE.
- `abort`  in  1  cancels the run. Effective only in ISSUE or WAIT.
- `num_steps`  in  STEP_W  number of steps to run. Latched on an accepted `start`.
- `step_done`  in  1  one-cycle pulse from the datapath marking the end of the current step.
- `step_start`  out  1  one-cycle pulse to the datapath that begins a step.
- `busy`  out  1  high in ISSUE and WAIT.
- `steps_done`  out  STEP_W  count of steps completed in the current or last run.
- `status`  out  8  bit 0 finish, bit 1 busy, bit 2 timeout, bit 3 aborted, bits [5:4] state code, bits [7:6] always 0.

## Operation
- State machine states and codes: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
- Reset values: state IDLE; `step_start`, `busy`, `steps_done` and all flags 0; `status`=8'h00.
- IDLE or DONE, `start`=1:
  - latch `num_steps` into `target`;
  - clear `steps_done`, finish, timeout and aborted;
  - next state ISSUE, or DONE with finish=1 if `num_steps`=0.
- ISSUE:
  - `step_start`=1 for exactly this one cycle;
  - load the watchdog with TIMEOUT_CYCLES (24-bit down-counter);
  - next state WAIT.
- WAIT, in this priority order:
  1. `abort` → DONE, aborted=1. A `step_done` in the same cycle is ignored and not counted.
  2. `step_done` → `steps_done`+1. If the new count equals `target`: DONE with finish=1. Otherwise: ISSUE.
  3. Watchdog = 1 → DONE, timeout=1, finish=0.
  4. Otherwise → decrement the watchdog.
- `abort` in ISSUE → DONE, aborted=1. `step_start` has already been driven high in that cycle.
- `step_done` outside WAIT is ignored.
- `start` in ISSUE or WAIT is ignored.
- `abort` in IDLE or DONE is ignored.
- DONE holds finish, timeout, aborted and `steps_done` until the next accepted `start`. There is no automatic return to IDLE.
- `steps_done` saturates by construction: it never passes `target`, and arithmetic is unsigned STEP_W.
- Reset asserted mid-run immediately forces all reset values. No pending pulse survives.

## Timing
- All outputs are registered, and `status` is updated on the same edge as state.
- `start` sampled at edge k:
  - ISSUE and `step_start`=1 during cycle k+1;
  - WAIT from k+2.
- Zero-step `start` at edge k: finish=1 and state DONE from cycle k+1.
- Final `step_done` sampled at edge j: finish=1 and `busy`=0 from cycle j+1.
- Intermediate `step_done` at edge j: next `step_start` in cycle j+1. Per-step overhead is 1 cycle plus datapath latency.
- Timeout: with no `step_done`, WAIT lasts exactly TIMEOUT_CYCLES cycles; timeout=1 in the following cycle.
- The datapath must not return `step_done` in the same cycle as `step_start`; such a pulse is ignored.
- `start` asserted continuously while in DONE re-launches a run on each entry to DONE. Software must pulse `start`.

## Test plan
- Normal run: reset, `num_steps`=3, `step_done` 4 cycles after each `step_start` → exactly 3 `step_start` pulses, `steps_done`=3, `status`=8'h31, `busy`=0.
- Zero steps: `start` with `num_steps`=0 → no `step_start`, `status`=8'h31 one cycle later.
- Timeout: TIMEOUT_CYCLES=8, `num_steps`=2, one `step_done` only → after 8 idle WAIT cycles `status`=8'h34, `steps_done`=1.
- Abort collision: `abort` and `step_done` in the same WAIT cycle of step 1 of 5 → `status`=8'h38, `steps_done`=0.
- Restart and ignore: `start` pulsed mid-run is ignored (`target` unchanged). After finish, `start` with `num_steps`=1 clears the flags; `status` reads 8'h12 in ISSUE and 8'h31 at the end.
- Reset mid-WAIT: drop `reset_n` while `busy`=1 → `status`=8'h00 and `step_start`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fdtd_run_sequencer.sv
// Sequences a programmed number of FDTD time steps with a per-step watchdog,
// and presents a registered status byte for the Nios II finish/status PIO.
module fdtd_run_sequencer #(
  parameter int unsigned STEP_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              step_done,
  output logic              step_start,
  output logic              busy,
  output logic [STEP_W-1:0] steps_done,
  output logic [7:0]        status
);

  // state | meaning
  // IDLE  | after reset, nothing run yet
  // ISSUE | step_start pulse cycle, watchdog loaded
  // WAIT  | waiting for step_done, watchdog counting down
  // DONE  | run ended (finish, timeout or abort), flags held
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [23:0] WD_LOAD = 24'(TIMEOUT_CYCLES);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic [STEP_W-1:0]   steps_d, steps_inc;
  logic [23:0]         wd_q, wd_d;
  logic                finish_q, finish_d;
  logic                timeout_q, timeout_d;
  logic                aborted_q, aborted_d;
  logic                busy_d;

  assign steps_inc = steps_done + STEP_W'(1);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    steps_d   = steps_done;
    wd_d      = wd_q;
    finish_d  = finish_q;
    timeout_d = timeout_q;
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d  = num_steps;
          steps_d   = '0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
          if (num_steps == '0) begin
            state_d  = DONE;
            finish_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            finish_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        wd_d = WD_LOAD;
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Abort wins over a coincident step_done, which is then not counted.
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (step_done) begin
          steps_d = steps_inc;
          if (steps_inc == target_q) begin
            state_d  = DONE;
            finish_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end else if (wd_q == 24'd1) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          finish_d  = 1'b0;
        end else begin
          wd_d = wd_q - 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == ISSUE) || (state_d == WAIT);

  // Outputs are registered from next-state values so they track state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      steps_done <= '0;
      wd_q       <= '0;
      finish_q   <= 1'b0;
      timeout_q  <= 1'b0;
      aborted_q  <= 1'b0;
      step_start <= 1'b0;
      busy       <= 1'b0;
      status     <= 8'h00;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      steps_done <= steps_d;
      wd_q       <= wd_d;
      finish_q   <= finish_d;
      timeout_q  <= timeout_d;
      aborted_q  <= aborted_d;
      step_start <= (state_d == ISSUE);
      busy       <= busy_d;
      status     <= {2'b00, state_d, aborted_d, timeout_d, busy_d, finish_d};
    end
  end

endmodule
